// File: rtl/encoder83_seq_pkg.sv
// Shared types and constants for the sequential 8-to-3 encoder.
package encoder83_seq_pkg;

    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    function automatic logic [3:0] popcount8(input logic [REQ_W-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < REQ_W; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/encoder83_seq_prio.sv
// prio_enc8: combinational highest-set-bit encode of an 8-bit vector, plus an "any bit set" flag.
module prio_enc8
    import encoder83_seq_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        // Ascending scan: the last set bit seen is the highest, so bit 7 wins.
        for (int i = 0; i < REQ_W; i++) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder83_seq.sv
// Captures a request vector and presents its set bits highest-first, one per rdy handshake.
// Optional ENCODER83_COUNT_EN adds cnt, the number of bits still to be served.
module encoder83_seq
    import encoder83_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] I,
    input  logic             load,
    input  logic             rdy,
    output logic [IDX_W-1:0] O,
    output logic             V,
    output logic             busy,
    output logic             done
`ifdef ENCODER83_COUNT_EN
    ,
    output logic [3:0]       cnt
`endif
);

    state_e           state_q, state_d;
    logic [REQ_W-1:0] pend_q, pend_d;
    logic [IDX_W-1:0] o_q, o_d;
    logic             v_q, v_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_any;
`ifdef ENCODER83_COUNT_EN
    logic [3:0]       cnt_q, cnt_d;
`endif

    // Encoding the next pending value lets O be registered with no bubble between bits.
    prio_enc8 u_prio (
        .req (pend_d),
        .idx (nxt_idx),
        .any (nxt_any)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
`ifdef ENCODER83_COUNT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (I != '0) begin
                        pend_d  = I;
                        state_d = SERVE;
`ifdef ENCODER83_COUNT_EN
                        cnt_d   = popcount8(I);
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SERVE: begin
                if (rdy) begin
                    pend_d = pend_q & ~(REQ_W'(1) << o_q);
`ifdef ENCODER83_COUNT_EN
                    cnt_d  = cnt_q - 4'd1;
`endif
                    if (pend_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
        v_d = (state_d == SERVE) && nxt_any;
        o_d = v_d ? nxt_idx : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            o_q     <= '0;
            v_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            o_q     <= o_d;
            v_q     <= v_d;
            done_q  <= done_d;
        end
    end

`ifdef ENCODER83_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

    assign O    = o_q;
    assign V    = v_q;
    assign busy = (state_q == SERVE);
    assign done = done_q;

endmodule

// File: tb/tb_encoder83_seq.sv
// Directed bench for encoder83_seq; observed word is {O, V, busy, done}.
module tb_encoder83_seq;

    logic       clk;
    logic       rst;
    logic [7:0] I;
    logic       load;
    logic       rdy;
    logic [2:0] O;
    logic       V;
    logic       busy;
    logic       done;
`ifdef ENCODER83_COUNT_EN
    logic [3:0] cnt;
`endif

    int total = 0;
    int bad   = 0;

    encoder83_seq dut (
        .clk  (clk),
        .rst  (rst),
        .I    (I),
        .load (load),
        .rdy  (rdy),
        .O    (O),
        .V    (V),
        .busy (busy),
        .done (done)
`ifdef ENCODER83_COUNT_EN
        ,
        .cnt  (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; I = 8'h00; load = 1'b0; rdy = 1'b0;
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_000) begin
            bad++;
            $display("FAIL reset_state got=%b want=%b", {O, V, busy, done}, 6'b000_000);
        end
`ifdef ENCODER83_COUNT_EN
        total++;
        if (cnt !== 4'd0) begin
            bad++;
            $display("FAIL reset_cnt got=%0d want=0", cnt);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        I = 8'h10; load = 1'b1; rdy = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if ({O, V, busy, done} !== {3'd4, 3'b110}) begin
            bad++;
            $display("FAIL single_serve got=%b want=%b", {O, V, busy, done}, {3'd4, 3'b110});
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_001) begin
            bad++;
            $display("FAIL single_done got=%b want=%b", {O, V, busy, done}, 6'b000_001);
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_000) begin
            bad++;
            $display("FAIL single_idle got=%b want=%b", {O, V, busy, done}, 6'b000_000);
        end
    endtask

    task automatic test_multi;
        logic [2:0] exp_o [4];
        logic [3:0] exp_c [4];
        exp_o = '{3'd7, 3'd5, 3'd2, 3'd0};
        exp_c = '{4'd4, 4'd3, 4'd2, 4'd1};
        I = 8'hA5; load = 1'b1; rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            load = 1'b0;
            total++;
            if ({O, V, busy, done} !== {exp_o[k], 3'b110}) begin
                bad++;
                $display("FAIL multi_step%0d got=%b want=%b", k, {O, V, busy, done}, {exp_o[k], 3'b110});
            end
`ifdef ENCODER83_COUNT_EN
            total++;
            if (cnt !== exp_c[k]) begin
                bad++;
                $display("FAIL multi_cnt%0d got=%0d want=%0d", k, cnt, exp_c[k]);
            end
`else
            if (exp_c[k] == 4'd0) $display("unexpected zero count entry %0d", k);
`endif
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_001) begin
            bad++;
            $display("FAIL multi_done got=%b want=%b", {O, V, busy, done}, 6'b000_001);
        end
`ifdef ENCODER83_COUNT_EN
        total++;
        if (cnt !== 4'd0) begin
            bad++;
            $display("FAIL multi_cnt_idle got=%0d want=0", cnt);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure;
        I = 8'h81; load = 1'b1; rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            load = 1'b0;
            total++;
            if ({O, V, busy, done} !== {3'd7, 3'b110}) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b want=%b", k, {O, V, busy, done}, {3'd7, 3'b110});
            end
        end
        rdy = 1'b1;
        tick();
        total++;
        if ({O, V, busy, done} !== {3'd0, 3'b110}) begin
            bad++;
            $display("FAIL bp_next got=%b want=%b", {O, V, busy, done}, {3'd0, 3'b110});
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_001) begin
            bad++;
            $display("FAIL bp_done got=%b want=%b", {O, V, busy, done}, 6'b000_001);
        end
        tick();
    endtask

    task automatic test_empty;
        I = 8'h00; load = 1'b1; rdy = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if ({O, V, busy, done} !== 6'b000_001) begin
            bad++;
            $display("FAIL empty_done got=%b want=%b", {O, V, busy, done}, 6'b000_001);
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_000) begin
            bad++;
            $display("FAIL empty_after got=%b want=%b", {O, V, busy, done}, 6'b000_000);
        end
    endtask

    task automatic test_ignored_load;
        I = 8'h80; load = 1'b1; rdy = 1'b0;
        tick();
        I = 8'h0F;
        total++;
        if ({O, V, busy, done} !== {3'd7, 3'b110}) begin
            bad++;
            $display("FAIL ign_first got=%b want=%b", {O, V, busy, done}, {3'd7, 3'b110});
        end
        tick();
        load = 1'b0; rdy = 1'b1;
        total++;
        if ({O, V, busy, done} !== {3'd7, 3'b110}) begin
            bad++;
            $display("FAIL ign_hold got=%b want=%b", {O, V, busy, done}, {3'd7, 3'b110});
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_001) begin
            bad++;
            $display("FAIL ign_done got=%b want=%b", {O, V, busy, done}, 6'b000_001);
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_000) begin
            bad++;
            $display("FAIL ign_idle got=%b want=%b", {O, V, busy, done}, 6'b000_000);
        end
    endtask

    task automatic test_back_to_back;
        I = 8'h40; load = 1'b1; rdy = 1'b1;
        tick();
        load = 1'b0;
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_001) begin
            bad++;
            $display("FAIL b2b_done got=%b want=%b", {O, V, busy, done}, 6'b000_001);
        end
        // Load while done is showing: this is the single IDLE cycle.
        I = 8'h03; load = 1'b1;
        tick();
        load = 1'b0;
        total++;
        if ({O, V, busy, done} !== {3'd1, 3'b110}) begin
            bad++;
            $display("FAIL b2b_first got=%b want=%b", {O, V, busy, done}, {3'd1, 3'b110});
        end
        tick();
        total++;
        if ({O, V, busy, done} !== {3'd0, 3'b110}) begin
            bad++;
            $display("FAIL b2b_second got=%b want=%b", {O, V, busy, done}, {3'd0, 3'b110});
        end
        tick();
        total++;
        if ({O, V, busy, done} !== 6'b000_001) begin
            bad++;
            $display("FAIL b2b_end got=%b want=%b", {O, V, busy, done}, 6'b000_001);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        I = 8'hA5; load = 1'b1; rdy = 1'b1;
        tick();
        load = 1'b0;
        tick();
        tick();
        total++;
        if ({O, V, busy, done} !== {3'd2, 3'b110}) begin
            bad++;
            $display("FAIL rstmid_pre got=%b want=%b", {O, V, busy, done}, {3'd2, 3'b110});
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({O, V, busy, done} !== 6'b000_000) begin
            bad++;
            $display("FAIL rstmid_async got=%b want=%b", {O, V, busy, done}, 6'b000_000);
        end
`ifdef ENCODER83_COUNT_EN
        total++;
        if (cnt !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_cnt got=%0d want=0", cnt);
        end
`endif
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({O, V, busy, done} !== 6'b000_000) begin
                bad++;
                $display("FAIL rstmid_after%0d got=%b want=%b", k, {O, V, busy, done}, 6'b000_000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_empty();
        test_ignored_load();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder83_seq.md
ENCODER83_SEQ -- requirements
Module: encoder83_seq

Interface
REQ-001 The block SHALL have no parameters; request width fixed at 8, index width fixed at 3.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 I  input  8  request vector, sampled only on an accepted load.
REQ-005 load  input  1  capture strobe for I.
REQ-006 rdy  input  1  consumer ready for the current index.
REQ-007 O  output  3  encoded index of the request currently presented.
REQ-008 V  output  1  O valid.
REQ-009 busy  output  1  high while a captured vector is being drained.
REQ-010 done  output  1  one-cycle pulse when a batch finishes.

Function
REQ-011 The FSM SHALL have two states: IDLE, SERVE; busy SHALL equal (state==SERVE).
REQ-012 In IDLE, load=1 with I!=0 SHALL capture I into an 8-bit pending register and enter SERVE at the next edge.
REQ-013 In IDLE, load=1 with I==0 SHALL stay in IDLE and pulse done for exactly the next cycle; V stays 0.
REQ-014 load SHALL be ignored while busy=1.
REQ-015 In SERVE, O SHALL be the highest-numbered set pending bit (bit 7 highest priority), and V SHALL be 1.
REQ-016 Latency: load accepted at edge t -> V=1 and valid O visible after edge t (first cycle of SERVE).
REQ-017 A transfer SHALL occur on an edge where V=1 and rdy=1; the pending bit at index O SHALL be cleared on that edge.
REQ-018 If the transfer clears the last pending bit, the FSM SHALL return to IDLE, V SHALL drop, and done SHALL pulse high for one cycle after the same edge.
REQ-019 If pending bits remain after a transfer, O SHALL update to the next-highest set bit with V held at 1 (no bubble cycle).
REQ-020 With V=1 and rdy=0, O and V SHALL hold unchanged.
REQ-021 O, V, done SHALL be registered outputs; O SHALL read 0 whenever V=0.
REQ-022 A new load SHALL be accepted in the cycle after done pulses (back-to-back batches: one IDLE cycle minimum).

Reset
REQ-023 On rst=1, asynchronously: state=IDLE, pending=0, O=0, V=0, busy=0, done=0 (and cnt=0 when present).
REQ-024 rst asserted mid-SERVE SHALL discard all pending bits; no done pulse SHALL be generated for the aborted batch.

Configuration
REQ-025 Macro ENCODER83_COUNT_EN, when defined, SHALL add output cnt[3:0]: loaded with popcount(I) on an accepted load, decremented by 1 on each transfer, reading 0 in IDLE.
REQ-026 Without ENCODER83_COUNT_EN the cnt port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, SERVE) and constants REQ_W=8, IDX_W=3.
REQ-028 One sub-module, prio_enc8, SHALL implement the combinational 8-to-3 highest-bit priority encode plus "any" flag; the FSM and registers live in encoder83_seq.

Verification
REQ-029 Reset mid-batch: load I=8'hA5, assert rst after two transfers -> V=0, busy=0, O=0 immediately; no done pulse; cnt=0.
REQ-030 Single bit: load I=8'h10, rdy=1 -> one cycle V=1 with O=4, then done pulse, busy=0.
REQ-031 Multi-bit drain: load I=8'hA5, rdy=1 -> O sequence 7,5,2,0 on consecutive cycles, then done; cnt sequence 4,3,2,1 (COUNT_EN).
REQ-032 Backpressure: load I=8'h81, rdy=0 for 3 cycles -> O=7, V=1 held; rdy=1 -> O=0 next, then done.
REQ-033 Empty and ignored loads: load I=8'h00 -> done pulse, V never high; load I=8'h0F while busy with 8'h80 -> only index 7 served.
